// File: rtl/time_package.sv
// Shared time types, limits and FSM state encoding for the time manager.
//   TIME_WIDTH  - bit width of every emulated time stamp
//   TIME_FORMAT - time stamp type
//   TIME_MAX    - reserved "never" time; no running clock reaches it
//   tm_state_e  - time manager FSM states
package time_package;

    localparam int unsigned TIME_WIDTH  = 32;
    localparam int unsigned EVENT_WIDTH = 32;

    typedef logic [TIME_WIDTH-1:0] TIME_FORMAT;

    localparam TIME_FORMAT TIME_MAX = '1;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        EVAL  = 2'd1,
        ISSUE = 2'd2
    } tm_state_e;

endpackage

// File: rtl/time_manager_if.sv
// Control/time bus between the time manager and its environment.
//   time_clock_in - next-edge time of each clock generator
//   run_req       - level, run continuously
//   step_req      - pulse, request step_count events
//   step_count    - events per step, sampled with step_req
//   time_next     - time broadcast to the clock generators
//   time_emu      - time of the last issued event
//   event_count   - number of issued events
//   step_done     - pulse when a step completes
//   order_err     - sticky non-monotonic time flag
// master: environment side, slave: time_manager side.
interface time_manager_if #(
    parameter int unsigned N_CLK     = 2,
    parameter int unsigned STEP_BITS = 16
);
    import time_package::*;

    TIME_FORMAT [N_CLK-1:0]  time_clock_in;
    logic                    run_req;
    logic                    step_req;
    logic [STEP_BITS-1:0]    step_count;
    TIME_FORMAT              time_next;
    TIME_FORMAT              time_emu;
    logic [EVENT_WIDTH-1:0]  event_count;
    logic                    step_done;
    logic                    order_err;

    modport master (
        output time_clock_in, run_req, step_req, step_count,
        input  time_next, time_emu, event_count, step_done, order_err
    );

    modport slave (
        input  time_clock_in, run_req, step_req, step_count,
        output time_next, time_emu, event_count, step_done, order_err
    );

endinterface

// File: rtl/time_min.sv
// Combinational unsigned minimum over N_CLK time stamps.
//   time_in    - N_CLK time stamps
//   time_min_c - smallest of them (ties resolve to any equal entry)
module time_min
    import time_package::*;
#(
    parameter int unsigned N_CLK = 2
) (
    input  TIME_FORMAT [N_CLK-1:0] time_in,
    output TIME_FORMAT             time_min_c
);

    // Linear reduction; N_CLK is small in practice.
    always_comb begin
        time_min_c = time_in[0];
        for (int i = 1; i < int'(N_CLK); i++) begin
            if (time_in[i] < time_min_c) begin
                time_min_c = time_in[i];
            end
        end
    end

endmodule

// File: rtl/time_manager.sv
// Central event scheduler for emulated clock generators. Each event takes
// two clk_sys cycles: EVAL registers the earliest pending clock edge, ISSUE
// broadcasts it on time_next for exactly one cycle. In PAUSE time_next holds
// TIME_MAX so no generator fires.
//   clk_sys - emulation system clock (rising edge)
//   rst     - asynchronous active-high reset
//   bus     - time_manager_if slave modport (requests, times, status)
module time_manager
    import time_package::*;
#(
    parameter int unsigned N_CLK     = 2,
    parameter int unsigned STEP_BITS = 16
) (
    input  logic           clk_sys,
    input  logic           rst,
    time_manager_if.slave  bus
);

    tm_state_e              state;
    TIME_FORMAT             min_c;
    TIME_FORMAT             min_q;
    TIME_FORMAT             time_next_q;
    TIME_FORMAT             time_emu_q;
    logic [EVENT_WIDTH-1:0] event_count_q;
    logic [STEP_BITS-1:0]   step_left;
    logic                   step_mode;
    logic                   step_done_q;
    logic                   order_err_q;

    time_min #(
        .N_CLK (N_CLK)
    ) u_time_min (
        .time_in    (bus.time_clock_in),
        .time_min_c (min_c)
    );

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state         <= PAUSE;
            min_q         <= TIME_MAX;
            time_next_q   <= TIME_MAX;
            time_emu_q    <= '0;
            event_count_q <= '0;
            step_left     <= '0;
            step_mode     <= 1'b0;
            step_done_q   <= 1'b0;
            order_err_q   <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            unique case (state)
                PAUSE: begin
                    time_next_q <= TIME_MAX;
                    // step_req wins over run_req; a zero-length step completes at once.
                    if (bus.step_req) begin
                        if (bus.step_count != '0) begin
                            step_left <= bus.step_count;
                            step_mode <= 1'b1;
                            state     <= EVAL;
                        end else begin
                            step_done_q <= 1'b1;
                        end
                    end else if (bus.run_req) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    // Loaded here so time_next carries the minimum during ISSUE only.
                    min_q       <= min_c;
                    time_next_q <= min_c;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    time_next_q <= TIME_MAX;
                    if (min_q == TIME_MAX) begin
                        // All clocks exhausted: nothing to issue, abandon any step.
                        step_mode <= 1'b0;
                        step_left <= '0;
                        state     <= PAUSE;
                    end else begin
                        time_emu_q    <= min_q;
                        event_count_q <= event_count_q + EVENT_WIDTH'(1);
                        if (min_q < time_emu_q) begin
                            order_err_q <= 1'b1;
                        end
                        if (step_mode) begin
                            step_left <= step_left - STEP_BITS'(1);
                            if (step_left == STEP_BITS'(1)) begin
                                step_mode   <= 1'b0;
                                step_done_q <= 1'b1;
                                state       <= PAUSE;
                            end else begin
                                state <= EVAL;
                            end
                        end else begin
                            state <= bus.run_req ? EVAL : PAUSE;
                        end
                    end
                end
                default: begin
                    time_next_q <= TIME_MAX;
                    state       <= PAUSE;
                end
            endcase
        end
    end

    assign bus.time_next   = time_next_q;
    assign bus.time_emu    = time_emu_q;
    assign bus.event_count = event_count_q;
    assign bus.step_done   = step_done_q;
    assign bus.order_err   = order_err_q;

endmodule

// File: doc/time_manager.md
TIME_MANAGER -- requirements
Module: time_manager

Interface
REQ-001 SHALL have parameter N_CLK, default 2, number of emulated clock generators arbitrated.
REQ-002 SHALL have parameter STEP_BITS, default 16, width of step_count.
REQ-003 SHALL have port clk_sys, input, 1, the single emulation system clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port time_clock_in, input, N_CLK x TIME_FORMAT, the current next-edge time of each clock generator.
REQ-006 SHALL have port run_req, input, 1, level; while high, events are issued continuously.
REQ-007 SHALL have port step_req, input, 1, single-cycle pulse requesting step_count events.
REQ-008 SHALL have port step_count, input, STEP_BITS, number of events per step, sampled with step_req.
REQ-009 SHALL have port time_next, output, TIME_FORMAT, the registered time broadcast to all clock generators.
REQ-010 SHALL have port time_emu, output, TIME_FORMAT, time of the last issued event.
REQ-011 SHALL have port event_count, output, 32, number of issued events; wraps modulo 2^32.
REQ-012 SHALL have port step_done, output, 1, single-cycle pulse when a step completes.
REQ-013 SHALL have port order_err, output, 1, sticky flag for non-monotonic time.

Function
REQ-014 SHALL implement FSM states PAUSE, EVAL and ISSUE.
REQ-015 In PAUSE, time_next SHALL equal TIME_MAX; TIME_MAX is reserved and never reached by a running clock, so no clock generator fires.
REQ-016 PAUSE SHALL go to EVAL when run_req=1, or when step_req=1 with step_count!=0; step_req SHALL take priority and load step_left=step_count with step_mode=1.
REQ-017 step_req with step_count=0 in PAUSE SHALL pulse step_done one cycle later, issue no event, and stay in PAUSE.
REQ-018 EVAL SHALL register min_q = unsigned minimum of all time_clock_in entries, with ties irrelevant, while time_next stays TIME_MAX, then go to ISSUE.
REQ-019 ISSUE SHALL drive time_next=min_q for exactly one cycle, and on exit SHALL set time_emu=min_q and increment event_count.
REQ-020 In ISSUE with step_mode=1, step_left SHALL decrement; at step_left=1 the FSM SHALL go to PAUSE, pulse step_done in the following cycle, and clear step_mode.
REQ-021 In ISSUE with step_mode=0, the FSM SHALL go to EVAL if run_req=1, else to PAUSE.
REQ-022 Event rate SHALL be one event per 2 clk_sys cycles, and time_next SHALL never match a clock in two consecutive cycles.
REQ-023 step_req outside PAUSE SHALL be ignored, and run_req SHALL be ignored while step_mode=1.
REQ-024 If min_q < time_emu in ISSUE, the block SHALL set order_err and still issue the event; order_err SHALL clear only on rst.
REQ-025 If min_q==TIME_MAX, meaning all clocks are exhausted, ISSUE SHALL count nothing and go to PAUSE.

Reset
REQ-026 rst=1 SHALL asynchronously force state=PAUSE, time_next=TIME_MAX, time_emu=0, event_count=0, step_left=0, step_mode=0, step_done=0, order_err=0.
REQ-027 Reset mid-step SHALL abandon the step without pulsing step_done.

Structure
REQ-028 TIME_FORMAT, TIME_WIDTH and TIME_MAX SHALL come from time_package, and the FSM state enum SHALL be defined there as well.
REQ-029 The minimum SHALL be a parameterised combinational sub-module time_min, reduced over N_CLK; all other logic SHALL be in time_manager.

Verification
REQ-030 Reset test: N_CLK=2, rst pulse, no requests -> time_next=TIME_MAX, event_count=0 indefinitely.
REQ-031 Run test: clocks at {10,25} advancing by {10,25} on match, run_req=1 -> time_next sequence 10,20,25,30,40,50(x2), one per 2 cycles.
REQ-032 Step test: step_req with step_count=3 -> exactly 3 ISSUE cycles, step_done 1 cycle after the third, time_emu=25, then PAUSE.
REQ-033 Zero-step test: step_count=0 -> step_done next cycle, event_count unchanged.
REQ-034 Ordering test: force time_clock_in[0]=5 after time_emu=20 -> order_err=1 and remains 1.
REQ-035 Mid-operation reset: rst asserted during ISSUE of a 5-event step -> immediate PAUSE outputs, no step_done.
